// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS main controller.
// Opcode/funct values follow the MIPS32 instruction word fields.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        ADDIEX = 4'd8,
        ADDIWB = 4'd9,
        BRANCH = 4'd10,
        JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

    localparam logic [1:0] PC_ALURES = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    function automatic logic is_known_op(input logic [5:0] op);
        return (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

    // States that stall on the memory handshake and are covered by the timeout.
    function automatic logic is_wait_state(input state_t s);
        return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
    endfunction

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Controller <-> datapath/memory bundle: instruction fields and status in, strobes out.
// master = controller side, slave = datapath/memory side.
interface mips_multicycle_control_if;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       overflow;
    logic       mem_ready;

    logic       IorD;
    logic       RegDest;
    logic       MemtoReg;
    logic       IRWrite;
    logic       RegWrite;
    logic       ALUSrcA;
    logic       Branch;
    logic       PCWrite;
    logic       MemWrite;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSrc;
    logic [2:0] ALUControl;
    logic [3:0] state_o;
    logic       exc_overflow;
    logic       exc_illegal;
    logic       err_timeout;

    modport master (
        input  opcode, funct, overflow, mem_ready,
        output IorD, RegDest, MemtoReg, IRWrite, RegWrite, ALUSrcA, Branch,
               PCWrite, MemWrite, ALUSrcB, PCSrc, ALUControl, state_o,
               exc_overflow, exc_illegal, err_timeout
    );

    modport slave (
        output opcode, funct, overflow, mem_ready,
        input  IorD, RegDest, MemtoReg, IRWrite, RegWrite, ALUSrcA, Branch,
               PCWrite, MemWrite, ALUSrcB, PCSrc, ALUControl, state_o,
               exc_overflow, exc_illegal, err_timeout
    );

endinterface

// File: rtl/alu_decoder.sv
// Combinational R-type funct decode to ALU operation, with legality and add/sub flags.
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_control,
    output logic       valid,
    output logic       is_addsub
);

    always_comb begin
        alu_control = ALU_ADD;
        valid       = 1'b1;
        is_addsub   = 1'b0;
        case (funct)
            FN_ADD: is_addsub = 1'b1;
            FN_SUB: begin
                alu_control = ALU_SUB;
                is_addsub   = 1'b1;
            end
            FN_AND:  alu_control = ALU_AND;
            FN_OR:   alu_control = ALU_OR;
            FN_SLT:  alu_control = ALU_SLT;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS main control FSM: sequences each instruction over 3-5 states,
// stalls on mem_ready with a bounded wait, and flags overflow/illegal/timeout.
module mips_multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                         ck,
    input  logic                         reset,
    mips_multicycle_control_if.master    ctl
);

    localparam int              CW         = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0]   WAIT_LIMIT = CW'(TIMEOUT_CYCLES - 1);

    state_t          state;
    logic [CW-1:0]   wait_cnt;
    logic            ovf_latch;

    logic [2:0]      fn_alu_control;
    logic            fn_valid;
    logic            fn_addsub;
    logic            waiting;
    logic            timeout;

    alu_decoder u_alu_decoder (
        .funct       (ctl.funct),
        .alu_control (fn_alu_control),
        .valid       (fn_valid),
        .is_addsub   (fn_addsub)
    );

    assign waiting = is_wait_state(state) && !ctl.mem_ready;
    // A ready in the threshold cycle is not a timeout: waiting already excludes it.
    assign timeout = waiting && (wait_cnt == WAIT_LIMIT);

    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            state     <= FETCH;
            wait_cnt  <= '0;
            ovf_latch <= 1'b0;
        end else begin
            // Wait states only hold while waiting, so a non-waiting cycle is a state change.
            wait_cnt <= (waiting && !timeout) ? wait_cnt + CW'(1) : '0;
            case (state)
                FETCH: begin
                    if (ctl.mem_ready) state <= DECODE;
                end
                DECODE: begin
                    case (ctl.opcode)
                        OP_LW, OP_SW: state <= MEMADR;
                        OP_R:         state <= EXEC;
                        OP_BEQ:       state <= BRANCH;
                        OP_ADDI:      state <= ADDIEX;
                        OP_J:         state <= JUMP;
                        default:      state <= FETCH;
                    endcase
                end
                MEMADR: state <= (ctl.opcode == OP_LW) ? MEMRD : MEMWR;
                MEMRD: begin
                    if (ctl.mem_ready)  state <= MEMWB;
                    else if (timeout)   state <= FETCH;
                end
                MEMWR: begin
                    if (ctl.mem_ready || timeout) state <= FETCH;
                end
                EXEC: begin
                    if (fn_valid) begin
                        ovf_latch <= ctl.overflow & fn_addsub;
                        state     <= ALUWB;
                    end else begin
                        state     <= FETCH;
                    end
                end
                ADDIEX: begin
                    ovf_latch <= ctl.overflow;
                    state     <= ADDIWB;
                end
                default: state <= FETCH;
            endcase
        end
    end

    // Strobes decode the registered state; reset gating keeps everything quiet
    // during reset, including the Mealy terms that follow mem_ready.
    always_comb begin
        ctl.IorD         = 1'b0;
        ctl.RegDest      = 1'b0;
        ctl.MemtoReg     = 1'b0;
        ctl.IRWrite      = 1'b0;
        ctl.RegWrite     = 1'b0;
        ctl.ALUSrcA      = 1'b0;
        ctl.Branch       = 1'b0;
        ctl.PCWrite      = 1'b0;
        ctl.MemWrite     = 1'b0;
        ctl.ALUSrcB      = SRCB_REGB;
        ctl.PCSrc        = PC_ALURES;
        ctl.ALUControl   = ALU_ADD;
        ctl.exc_overflow = 1'b0;
        ctl.exc_illegal  = 1'b0;
        ctl.err_timeout  = 1'b0;
        if (!reset) begin
            case (state)
                FETCH: begin
                    ctl.ALUSrcB     = SRCB_FOUR;
                    ctl.PCSrc       = PC_ALURES;
                    ctl.IRWrite     = ctl.mem_ready;
                    ctl.PCWrite     = ctl.mem_ready;
                    ctl.err_timeout = timeout;
                end
                DECODE: begin
                    ctl.ALUSrcB     = SRCB_IMM_SL2;
                    ctl.exc_illegal = !is_known_op(ctl.opcode);
                end
                MEMADR: begin
                    ctl.ALUSrcA = 1'b1;
                    ctl.ALUSrcB = SRCB_IMM;
                end
                MEMRD: begin
                    ctl.IorD        = 1'b1;
                    ctl.err_timeout = timeout;
                end
                MEMWB: begin
                    ctl.MemtoReg = 1'b1;
                    ctl.RegWrite = 1'b1;
                end
                MEMWR: begin
                    ctl.IorD        = 1'b1;
                    ctl.MemWrite    = 1'b1;
                    ctl.err_timeout = timeout;
                end
                EXEC: begin
                    ctl.ALUSrcA     = 1'b1;
                    ctl.ALUSrcB     = SRCB_REGB;
                    ctl.ALUControl  = fn_alu_control;
                    ctl.exc_illegal = !fn_valid;
                end
                ALUWB: begin
                    ctl.RegDest      = 1'b1;
                    ctl.RegWrite     = !ovf_latch;
                    ctl.exc_overflow = ovf_latch;
                end
                ADDIEX: begin
                    ctl.ALUSrcA = 1'b1;
                    ctl.ALUSrcB = SRCB_IMM;
                end
                ADDIWB: begin
                    ctl.RegWrite     = !ovf_latch;
                    ctl.exc_overflow = ovf_latch;
                end
                BRANCH: begin
                    ctl.ALUSrcA    = 1'b1;
                    ctl.ALUSrcB    = SRCB_REGB;
                    ctl.ALUControl = ALU_SUB;
                    ctl.Branch     = 1'b1;
                    ctl.PCSrc      = PC_ALUOUT;
                end
                JUMP: begin
                    ctl.PCWrite = 1'b1;
                    ctl.PCSrc   = PC_JUMP;
                end
                default: ;
            endcase
        end
    end

    assign ctl.state_o = state;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed scenarios followed by randomized instructions scored against a per-instruction
// model of cycle count and strobe/pulse totals.
module tb_mips_multicycle_control;
    import mips_ctrl_pkg::*;

    localparam int TO = 4;

    logic ck = 1'b0;
    logic reset;

    mips_multicycle_control_if bus ();

    mips_multicycle_control #(.TIMEOUT_CYCLES(TO)) dut (
        .ck    (ck),
        .reset (reset),
        .ctl   (bus.master)
    );

    always #5 ck = ~ck;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int len;
        int irw, pcw, regw, memw, br, eov, eill, eto;
    } exp_t;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 2 time units later.
    task automatic cyc(input logic rdy);
        @(negedge ck);
        reset         = 1'b0;
        bus.mem_ready = rdy;
        #2;
    endtask

    task automatic start(input logic [5:0] op, input logic [5:0] fn, input logic ovf, input logic rdy);
        @(negedge ck);
        reset         = 1'b0;
        bus.opcode    = op;
        bus.funct     = fn;
        bus.overflow  = ovf;
        bus.mem_ready = rdy;
        #2;
    endtask

    // Instruction-level view: cycles spent and how many times each strobe/pulse fires.
    function automatic exp_t model(input logic [5:0] op, input logic [5:0] fn, input logic ovf,
                                   input int wf, input int wd);
        exp_t e;
        logic fn_ok;
        logic fn_as;
        e = '{default: 0};
        fn_ok = (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) || (fn == FN_OR) || (fn == FN_SLT);
        fn_as = (fn == FN_ADD) || (fn == FN_SUB);
        if (wf >= TO) begin
            e.len = TO;
            e.eto = 1;
            return e;
        end
        e.len = wf + 1;
        e.irw = 1;
        e.pcw = 1;
        case (op)
            OP_J:    begin e.len += 2; e.pcw += 1; end
            OP_BEQ:  begin e.len += 2; e.br = 1; end
            OP_ADDI: begin e.len += 3; if (ovf) e.eov = 1; else e.regw = 1; end
            OP_R: begin
                if (!fn_ok) begin
                    e.len += 2; e.eill = 1;
                end else begin
                    e.len += 3;
                    if (ovf && fn_as) e.eov = 1; else e.regw = 1;
                end
            end
            OP_LW: begin
                if (wd >= TO) begin e.len += 2 + TO; e.eto = 1; end
                else begin e.len += 2 + wd + 2; e.regw = 1; end
            end
            OP_SW: begin
                if (wd >= TO) begin e.len += 2 + TO; e.eto = 1; e.memw = TO; end
                else begin e.len += 2 + wd + 1; e.memw = wd + 1; end
            end
            default: begin e.len += 1; e.eill = 1; end
        endcase
        return e;
    endfunction

    function automatic int pick_wait();
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 6) return 0;
        if (r < 9) return int'($urandom_range(1, TO - 1));
        return TO;
    endfunction

    initial begin
        int   lw_states [5];
        logic [5:0] op, fn;
        logic ovf;
        int   wf, wd, m0;
        exp_t e;
        logic rdy_q [$];
        int   o_irw, o_pcw, o_regw, o_memw, o_br, o_eov, o_eill, o_eto, o_excl;

        lw_states = '{0, 1, 2, 3, 4};

        reset         = 1'b1;
        bus.opcode    = OP_LW;
        bus.funct     = FN_ADD;
        bus.overflow  = 1'b0;
        bus.mem_ready = 1'b1;
        #2;
        chk("rst_state",   32'(bus.state_o), 0);
        chk("rst_irwrite", 32'(bus.IRWrite), 0);
        chk("rst_pcwrite", 32'(bus.PCWrite), 0);
        chk("rst_alusrcb", 32'(bus.ALUSrcB), 0);
        chk("rst_pulses",  32'({bus.exc_overflow, bus.exc_illegal, bus.err_timeout}), 0);

        // LW, memory always ready
        for (int k = 0; k < 5; k++) begin
            if (k == 0) start(OP_LW, FN_ADD, 1'b0, 1'b1);
            else        cyc(1'b1);
            chk("lw_state",    32'(bus.state_o),  32'(lw_states[k]));
            chk("lw_regwrite", 32'(bus.RegWrite), 32'(k == 4));
            chk("lw_memtoreg", 32'(bus.MemtoReg), 32'(k == 4));
        end

        // R add with overflow, then without
        start(OP_R, FN_ADD, 1'b1, 1'b1);
        cyc(1'b1);
        cyc(1'b1);
        chk("radd_exec_aluctl", 32'(bus.ALUControl), 32'(3'b010));
        cyc(1'b1);
        chk("rovf_state",    32'(bus.state_o),      7);
        chk("rovf_regwrite", 32'(bus.RegWrite),     0);
        chk("rovf_exc",      32'(bus.exc_overflow), 1);
        start(OP_R, FN_ADD, 1'b0, 1'b1);
        chk("rovf_pulse_end", 32'(bus.exc_overflow), 0);
        cyc(1'b1);
        cyc(1'b1);
        cyc(1'b1);
        chk("radd_regwrite", 32'(bus.RegWrite),     1);
        chk("radd_regdest",  32'(bus.RegDest),      1);
        chk("radd_noexc",    32'(bus.exc_overflow), 0);

        // Fetch stalls 3 cycles (one short of the timeout), then J
        for (int k = 0; k < 3; k++) begin
            if (k == 0) start(OP_J, FN_ADD, 1'b0, 1'b0);
            else        cyc(1'b0);
            chk("fwait_irwrite", 32'(bus.IRWrite), 0);
            chk("fwait_pcwrite", 32'(bus.PCWrite), 0);
        end
        cyc(1'b1);
        chk("fready_irwrite", 32'(bus.IRWrite),     1);
        chk("fready_pcwrite", 32'(bus.PCWrite),     1);
        chk("fready_no_to",   32'(bus.err_timeout), 0);
        cyc(1'b1);
        chk("fready_decode",  32'(bus.state_o), 1);
        chk("decode_irwrite", 32'(bus.IRWrite), 0);
        cyc(1'b0);
        chk("j_pcwrite", 32'(bus.PCWrite), 1);
        chk("j_pcsrc",   32'(bus.PCSrc),   2);

        // SW with memory never ready
        start(OP_SW, FN_ADD, 1'b0, 1'b1);
        cyc(1'b1);
        cyc(1'b1);
        for (int k = 0; k < TO; k++) begin
            cyc(1'b0);
            chk("swto_state",    32'(bus.state_o),     5);
            chk("swto_memwrite", 32'(bus.MemWrite),    1);
            chk("swto_timeout",  32'(bus.err_timeout), 32'(k == TO - 1));
        end

        // Illegal opcode
        start(6'b111111, FN_ADD, 1'b0, 1'b1);
        chk("ill_fetch_state", 32'(bus.state_o),  0);
        chk("ill_fetch_memwr", 32'(bus.MemWrite), 0);
        cyc(1'b1);
        chk("ill_exc",      32'(bus.exc_illegal), 1);
        chk("ill_regwrite", 32'(bus.RegWrite),    0);
        chk("ill_memwrite", 32'(bus.MemWrite),    0);
        chk("ill_pcwrite",  32'(bus.PCWrite),     0);

        // BEQ
        start(OP_BEQ, FN_ADD, 1'b0, 1'b1);
        chk("beq_fetch_state", 32'(bus.state_o),     0);
        chk("ill_pulse_end",   32'(bus.exc_illegal), 0);
        cyc(1'b1);
        cyc(1'b1);
        chk("beq_branch", 32'(bus.Branch),     1);
        chk("beq_pcsrc",  32'(bus.PCSrc),      1);
        chk("beq_aluctl", 32'(bus.ALUControl), 32'(3'b110));

        // Reset during MEMWB
        start(OP_LW, FN_ADD, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) cyc(1'b1);
        chk("mrst_pre_regwrite", 32'(bus.RegWrite), 1);
        reset = 1'b1;
        #1;
        chk("mrst_regwrite", 32'(bus.RegWrite), 0);
        chk("mrst_state",    32'(bus.state_o),  0);
        cyc(1'b1);
        chk("mrst_rel_state",   32'(bus.state_o), 0);
        chk("mrst_rel_irwrite", 32'(bus.IRWrite), 1);
        reset = 1'b1;

        // Randomized instructions
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 6))
                0: op = OP_R;
                1: op = OP_LW;
                2: op = OP_SW;
                3: op = OP_BEQ;
                4: op = OP_ADDI;
                5: op = OP_J;
                default: begin
                    op = 6'($urandom);
                    while (is_known_op(op)) op = 6'($urandom);
                end
            endcase
            case ($urandom_range(0, 5))
                0: fn = FN_ADD;
                1: fn = FN_SUB;
                2: fn = FN_AND;
                3: fn = FN_OR;
                4: fn = FN_SLT;
                default: fn = 6'b110011;
            endcase
            ovf = 1'($urandom);
            wf  = pick_wait();
            wd  = pick_wait();
            e   = model(op, fn, ovf, wf, wd);

            rdy_q.delete();
            for (int k = 0; k < e.len; k++) rdy_q.push_back(1'($urandom));
            for (int k = 0; k < wf && k < TO; k++) rdy_q[k] = 1'b0;
            if (wf < TO) begin
                rdy_q[wf] = 1'b1;
                if (op == OP_LW || op == OP_SW) begin
                    m0 = wf + 3;
                    for (int k = 0; k < wd && k < TO; k++) rdy_q[m0 + k] = 1'b0;
                    if (wd < TO) rdy_q[m0 + wd] = 1'b1;
                end
            end

            o_irw = 0; o_pcw = 0; o_regw = 0; o_memw = 0; o_br = 0;
            o_eov = 0; o_eill = 0; o_eto = 0; o_excl = 0;
            for (int k = 0; k < e.len; k++) begin
                if (k == 0) begin
                    start(op, fn, ovf, rdy_q[0]);
                    chk("rnd_start_fetch", 32'(bus.state_o), 0);
                end else begin
                    cyc(rdy_q[k]);
                end
                o_irw  += 32'(bus.IRWrite);
                o_pcw  += 32'(bus.PCWrite);
                o_regw += 32'(bus.RegWrite);
                o_memw += 32'(bus.MemWrite);
                o_br   += 32'(bus.Branch);
                o_eov  += 32'(bus.exc_overflow);
                o_eill += 32'(bus.exc_illegal);
                o_eto  += 32'(bus.err_timeout);
                o_excl += 32'(bus.IRWrite & bus.RegWrite);
            end
            chk("rnd_irwrite",  32'(o_irw),  32'(e.irw));
            chk("rnd_pcwrite",  32'(o_pcw),  32'(e.pcw));
            chk("rnd_regwrite", 32'(o_regw), 32'(e.regw));
            chk("rnd_memwrite", 32'(o_memw), 32'(e.memw));
            chk("rnd_branch",   32'(o_br),   32'(e.br));
            chk("rnd_exc_ovf",  32'(o_eov),  32'(e.eov));
            chk("rnd_exc_ill",  32'(o_eill), 32'(e.eill));
            chk("rnd_timeout",  32'(o_eto),  32'(e.eto));
            chk("rnd_ir_rf_excl", 32'(o_excl), 0);
        end

        // The last instruction must have returned to FETCH
        cyc(1'b0);
        chk("rnd_final_fetch", 32'(bus.state_o), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
Main control FSM for the multicycle MIPS datapath. It decodes opcode/funct from the instruction register and sequences one instruction over 3–5 states. It drives every datapath control strobe (IorD, RegDest, MemtoReg, IRWrite, RegWrite, ALUSrcA/B, ALUControl, PCSrc, Branch, PCWrite) plus MemWrite to memory. It adds a memory-ready handshake with timeout, and overflow/illegal-opcode exception flags.

Parameters:
TIMEOUT_CYCLES, 16, cycles a memory state may wait for mem_ready before aborting (>=2)

Ports:
ck  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
opcode  input  6  instruction[31:26] from instruction register
funct  input  6  instruction[5:0]
overflow  input  1  ALU overflow (combinational, valid in execute states)
mem_ready  input  1  memory read data valid / write accepted this cycle
IorD, RegDest, MemtoReg, IRWrite, RegWrite, ALUSrcA, Branch, PCWrite, MemWrite  output  1 each  datapath/memory strobes
ALUSrcB  output  2  00 regB, 01 const 4, 10 signext, 11 signext<<2
PCSrc  output  2  00 ALUResult, 01 ALUOut, 10 jump address
ALUControl  output  3  010 add, 110 sub, 000 and, 001 or, 111 slt
state_o  output  4  current state encoding (debug)
exc_overflow, exc_illegal, err_timeout  output  1 each  one-cycle pulses

Behaviour:
- Reset: state=FETCH, wait counter=0, overflow latch=0. While reset=1 all strobes and pulses are 0; state_o=FETCH.
- Opcodes: R 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000, J 000010. Functs: add 100000, sub 100010, and 100100, or 100101, slt 101010.
- Each state's outputs are listed below. Any strobe not named is 0; ALUControl defaults to 010.
- FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, PCSrc=00. IRWrite=PCWrite=mem_ready (Mealy gating). Holds until mem_ready=1, then goes to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11 (branch target into ALUOut). Next state: LW/SW->MEMADR, R->EXEC, BEQ->BRANCH, ADDI->ADDIEX, J->JUMP. Any other opcode: exc_illegal pulse, next FETCH.
- MEMADR: ALUSrcA=1, ALUSrcB=10. Next: MEMRD if LW, MEMWR if SW.
- MEMRD: IorD=1. Holds until mem_ready, then MEMWB.
- MEMWB: RegDest=0, MemtoReg=1, RegWrite=1. Next FETCH.
- MEMWR: IorD=1, MemWrite=1, held while waiting. Next FETCH on mem_ready.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUControl from funct. Undefined funct: exc_illegal pulse, next FETCH. Otherwise overflow latch <= overflow & (funct is add or sub), next ALUWB.
- ALUWB: RegDest=1, MemtoReg=0. RegWrite = !latch. If latch=1: exc_overflow pulse, no register write. Next FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, add. Latch <= overflow. Next ADDIWB.
- ADDIWB: RegDest=0, MemtoReg=0, RegWrite = !latch, exc_overflow on latch. Next FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, sub, Branch=1, PCSrc=01. Next FETCH.
- JUMP: PCWrite=1, PCSrc=10. Next FETCH.
- Latency with mem_ready tied high: LW 5, SW 4, R 4, ADDI 4, BEQ 3, J 3 cycles.
- Wait counter:
  - Counts consecutive cycles in FETCH/MEMRD/MEMWR with mem_ready=0; clears on state change or mem_ready.
  - When it reaches TIMEOUT_CYCLES-1 with mem_ready still 0: err_timeout pulse, next FETCH.
  - On this abort no strobe that commits state is asserted (PC, IR, regfile, memory unchanged). MemWrite is dropped on that cycle's exit.
  - mem_ready=1 in the same cycle as the timeout threshold: ready wins.
- Reset asserted mid-instruction: immediate return to FETCH and outputs 0. No partial write is issued after the reset edge.
- Mutual exclusion: IRWrite and RegWrite are never both 1. MemWrite is only 1 in MEMWR.

Decomposition:
- Package mips_ctrl_pkg holds:
  - state_t enum, 4-bit: FETCH=0, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, ADDIEX, ADDIWB, BRANCH, JUMP.
  - Opcode and funct localparams.
  - ALU code localparams.
  - ALUSrcB and PCSrc select localparams.
- Sub-module alu_decoder: combinational funct -> ALUControl, plus a valid flag and an is_addsub flag. It is instantiated for EXEC.

Test Plan:
- LW (opcode 100011), mem_ready=1 → states FETCH,DECODE,MEMADR,MEMRD,MEMWB over 5 cycles. RegWrite=1 and MemtoReg=1 only in cycle 5.
- R add (funct 100000) with overflow=1 in EXEC → ALUWB has RegWrite=0 and exc_overflow=1 for exactly one cycle. Repeat with overflow=0 → RegWrite=1, RegDest=1.
- FETCH with mem_ready low for 3 cycles, then high → IRWrite/PCWrite stay 0 for 3 cycles, then pulse once. DECODE follows next cycle.
- SW with mem_ready never asserted, TIMEOUT_CYCLES=4 → MemWrite high for 4 cycles in MEMWR, then err_timeout pulse and return to FETCH.
- Opcode 111111 → exc_illegal pulse in DECODE, back to FETCH, no RegWrite/MemWrite/PCWrite. BEQ → Branch=1, PCSrc=01, ALUControl=110 in cycle 3. J → PCWrite=1, PCSrc=10.
- reset raised during MEMWB → RegWrite drops to 0 asynchronously. After release, FETCH with state_o=0.
